// File: rtl/rs485_poll_scheduler_if.sv
// Bus bundle between the poll scheduler, the UART receiver/serializer and the two packet sources.
// The master modport is the scheduler side; the slave modport is its environment.
interface rs485_poll_scheduler_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] src_data0;
    logic [7:0] src_data1;
    logic [1:0] src_valid;
    logic [1:0] src_last;
    logic [1:0] src_ready;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       de;

    modport master (
        input  rx_byte,
        input  rx_valid,
        input  src_data0,
        input  src_data1,
        input  src_valid,
        input  src_last,
        input  tx_done,
        output src_ready,
        output tx_start,
        output tx_byte,
        output de
    );

    modport slave (
        output rx_byte,
        output rx_valid,
        output src_data0,
        output src_data1,
        output src_valid,
        output src_last,
        output tx_done,
        input  src_ready,
        input  tx_start,
        input  tx_byte,
        input  de
    );
endinterface

// File: rtl/rs485_poll_scheduler.sv
// Half-duplex RS485 poll responder: round-robin grant of one of two packet sources per poll,
// byte streaming into the serializer, and driver-enable with lead/lag turnaround guard.
module rs485_poll_scheduler #(
    parameter logic [7:0]  POLL_CMD  = 8'h01,
    parameter logic [7:0]  NAK_BYTE  = 8'h15,
    parameter int unsigned GUARD_CYC = 2,
    parameter int unsigned MAX_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    rs485_poll_scheduler_if.master        bus,
    output logic [1:0]                    grant,
    output logic                          busy,
    output logic                          overlen,
    output logic [7:0]                    poll_drop
);

    localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);
    localparam logic [GW-1:0] GuardEnd = GW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] CntEnd   = CW'(MAX_BYTES - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLead   = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StWaitTx = 3'd3;
    localparam logic [2:0] StLag    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          rr_q, rr_d;
    logic [1:0]    grant_q, grant_d;
    logic          tx_start_q, tx_start_d;
    logic [1:0]    src_ready_q, src_ready_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          overlen_q, overlen_d;
    logic [7:0]    poll_drop_q, poll_drop_d;
    logic          de_q, de_d;
    logic          busy_q, busy_d;

    logic          poll_hit;
    logic          try_load;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          cap_hit;

    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        tx_start_d  = 1'b0;
        src_ready_d = 2'b00;
        tx_byte_d   = tx_byte_q;
        overlen_d   = overlen_q;
        poll_drop_d = poll_drop_q;
        try_load    = 1'b0;

        poll_hit  = bus.rx_valid && (bus.rx_byte == POLL_CMD);
        sel_valid = |(grant_q & bus.src_valid);
        sel_data  = grant_q[1] ? bus.src_data1 : bus.src_data0;
        sel_last  = grant_q[1] ? bus.src_last[1] : bus.src_last[0];
        cap_hit   = (cnt_q == CntEnd);

        case (state_q)
            StIdle: begin
                if (poll_hit) begin
                    // rr_q names the source granted most recently; the other one wins a tie.
                    case (bus.src_valid)
                        2'b01: begin
                            grant_d = 2'b01;
                            rr_d    = 1'b0;
                        end
                        2'b10: begin
                            grant_d = 2'b10;
                            rr_d    = 1'b1;
                        end
                        2'b11: begin
                            grant_d = rr_q ? 2'b01 : 2'b10;
                            rr_d    = ~rr_q;
                        end
                        default: grant_d = 2'b00;
                    endcase
                    state_d = StLead;
                    guard_d = '0;
                    cnt_d   = '0;
                end
            end
            StLead: begin
                // The last lead cycle already evaluates the first byte so that the registered
                // tx_start lands exactly GUARD_CYC cycles after de rises.
                if (guard_q == GuardEnd) begin
                    try_load = 1'b1;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            StLoad: begin
                try_load = 1'b1;
            end
            StWaitTx: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        state_d = StLag;
                        guard_d = '0;
                    end else begin
                        try_load = 1'b1;
                    end
                end
            end
            StLag: begin
                if (guard_q == GuardEnd) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase

        if (try_load) begin
            if (grant_q == 2'b00) begin
                tx_start_d = 1'b1;
                tx_byte_d  = NAK_BYTE;
                last_d     = 1'b1;
                state_d    = StWaitTx;
            end else if (sel_valid) begin
                tx_start_d  = 1'b1;
                src_ready_d = grant_q;
                tx_byte_d   = sel_data;
                last_d      = sel_last || cap_hit;
                cnt_d       = cnt_q + CW'(1);
                state_d     = StWaitTx;
                if (cap_hit && !sel_last) begin
                    overlen_d = 1'b1;
                end
            end else begin
                state_d = StLoad;
            end
        end

        if ((state_q != StIdle) && poll_hit && (poll_drop_q != 8'hff)) begin
            poll_drop_d = poll_drop_q + 8'd1;
        end

        de_d   = (state_d != StIdle);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            guard_q     <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            rr_q        <= 1'b1;
            grant_q     <= 2'b00;
            tx_start_q  <= 1'b0;
            src_ready_q <= 2'b00;
            tx_byte_q   <= 8'h00;
            overlen_q   <= 1'b0;
            poll_drop_q <= 8'h00;
            de_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            src_ready_q <= src_ready_d;
            tx_byte_q   <= tx_byte_d;
            overlen_q   <= overlen_d;
            poll_drop_q <= poll_drop_d;
            de_q        <= de_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.src_ready = src_ready_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.de        = de_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign overlen       = overlen_q;
    assign poll_drop     = poll_drop_q;

endmodule
